// File: rtl/debounce_pkg.sv
// Shared state encodings and defaults for the debounce_edge input conditioner.
package debounce_pkg;

   typedef enum logic [1:0] {
      S_LOW    = 2'b00,
      S_WAIT_H = 2'b01,
      S_HIGH   = 2'b11,
      S_WAIT_L = 2'b10
   } state_e;

   localparam int unsigned STABLE_CYCLES_DEF = 4;
   localparam int unsigned CNT_W_DEF         = 8;

endpackage

// File: rtl/debounce_edge_sync2.sv
// Two-flop synchroniser for an asynchronous level, synchronous active-high reset.
module sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic sy1_q;
   logic s_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sy1_q <= 1'b0;
         s_q   <= 1'b0;
      end else begin
         sy1_q <= d;
         s_q   <= sy1_q;
      end
   end

   assign q = s_q;

endmodule

// File: rtl/debounce_edge.sv
// Synchronise, debounce and edge-detect a raw level input.
// Optional debounced-rise counter enabled by DEBOUNCE_EDGE_EVTCNT_EN.
module debounce_edge
   import debounce_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
   parameter int unsigned CNT_W         = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din,
   output logic             dout,
   output logic             rise,
   output logic             fall,
   output logic             busy,
   output logic [CNT_W-1:0] evt_cnt
);

   localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic          dout_q;
   logic          rise_q;
   logic          fall_q;
   logic          busy_q;
   logic          s;
   logic          rise_d;

   sync2 u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (din),
      .q     (s)
   );

   // Final agreeing sample of a rising wait: the edge that sets rise.
   assign rise_d = (state_q == S_WAIT_H) && s && (cnt_q == CNT_MAX);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_LOW;
         cnt_q   <= '0;
         dout_q  <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         case (state_q)
            S_LOW: begin
               if (s) begin
                  state_q <= S_WAIT_H;
                  cnt_q   <= CW'(1);
                  busy_q  <= 1'b1;
               end
            end
            S_WAIT_H: begin
               if (!s) begin
                  state_q <= S_LOW;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else if (cnt_q == CNT_MAX) begin
                  state_q <= S_HIGH;
                  cnt_q   <= '0;
                  dout_q  <= 1'b1;
                  rise_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_HIGH: begin
               if (!s) begin
                  state_q <= S_WAIT_L;
                  cnt_q   <= CW'(1);
                  busy_q  <= 1'b1;
               end
            end
            S_WAIT_L: begin
               if (s) begin
                  state_q <= S_HIGH;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else if (cnt_q == CNT_MAX) begin
                  state_q <= S_LOW;
                  cnt_q   <= '0;
                  dout_q  <= 1'b0;
                  fall_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               state_q <= S_LOW;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign dout = dout_q;
   assign rise = rise_q;
   assign fall = fall_q;
   assign busy = busy_q;

`ifdef DEBOUNCE_EDGE_EVTCNT_EN
   logic [CNT_W-1:0] evt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         evt_q <= '0;
      end else if (rise_d) begin
         evt_q <= evt_q + CNT_W'(1);
      end
   end

   assign evt_cnt = evt_q;
`else
   assign evt_cnt = '0;
`endif

endmodule
